// File: rtl/fifo_sram_arbiter_pkg.sv
// Shared types and defaults for the fifo_SRAM user-port arbiter.
package fifo_sram_arbiter_pkg;

   localparam int unsigned DefaultDepth   = 1024;
   localparam int unsigned DefaultTimeout = 64;
   localparam int unsigned DefaultDw      = 32;

   typedef enum logic [3:0] {
      StIdle    = 4'd0,
      StWrIssue = 4'd1,
      StWrWait  = 4'd2,
      StRdIssue = 4'd3,
      StRdWait  = 4'd4
   } state_e;

   typedef enum logic {
      GrantWr = 1'b0,
      GrantRd = 1'b1
   } grant_e;

endpackage

// File: rtl/fifo_sram_arbiter_if.sv
// Requester and fifo_SRAM user-port signals seen by the arbiter; master is the arbiter side.
interface fifo_sram_arbiter_if #(
   parameter int unsigned DW    = fifo_sram_arbiter_pkg::DefaultDw,
   parameter int unsigned DEPTH = fifo_sram_arbiter_pkg::DefaultDepth
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic          wr_req;
   logic [DW-1:0] wr_data;
   logic          wr_ack;
   logic          rd_req;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic [DW-1:0] fifo_din;
   logic          fifo_we;
   logic          fifo_re;
   logic [DW-1:0] fifo_dout;
   logic          fifo_rdy;
   logic          fifo_busy;
   logic          fifo_ovf;
   logic [CW-1:0] fill_count;
   logic          full;
   logic          empty;
   logic          err_timeout;
   logic          err_ovf;

   modport master (
      input  wr_req, wr_data, rd_req, fifo_dout, fifo_rdy, fifo_busy, fifo_ovf,
      output wr_ack, rd_data, rd_valid, fifo_din, fifo_we, fifo_re, fill_count, full, empty,
             err_timeout, err_ovf
   );

   modport slave (
      output wr_req, wr_data, rd_req, fifo_dout, fifo_rdy, fifo_busy, fifo_ovf,
      input  wr_ack, rd_data, rd_valid, fifo_din, fifo_we, fifo_re, fill_count, full, empty,
             err_timeout, err_ovf
   );

endinterface

// File: rtl/fifo_sram_arbiter_arb_op_timer.sv
// Wait-state cycle counter: cleared on issue, counts while enabled, saturates at TIMEOUT.
module arb_op_timer #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] Limit = TW'(TIMEOUT);

   logic [TW-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_q <= '0;
      end else if (enable && !expired) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign expired = (count_q == Limit);

endmodule

// File: rtl/fifo_sram_arbiter.sv
// Arbitrates one fifo_SRAM user port between a level-request writer and reader,
// issuing single-cycle strobes and tracking occupancy.
module fifo_sram_arbiter
   import fifo_sram_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH   = DefaultDepth,
   parameter int unsigned TIMEOUT = DefaultTimeout,
   parameter int unsigned DW      = DefaultDw
) (
   input logic                 clk,
   input logic                 rst,
   fifo_sram_arbiter_if.master bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FillMax = CW'(DEPTH);

   state_e        state_q;
   grant_e        last_grant_q;
   logic [CW-1:0] fill_q;
   logic [DW-1:0] rd_data_q;
   logic [DW-1:0] fifo_din_q;
   logic          wr_ack_q;
   logic          rd_valid_q;
   logic          fifo_we_q;
   logic          fifo_re_q;
   logic          err_timeout_q;
   logic          err_ovf_q;
   logic          guard_q;

   logic full, empty, wr_elig, rd_elig, contend, grant_wr, grant_rd;
   logic timer_clear, timer_en, expired;

   assign full    = (fill_q == FillMax);
   assign empty   = (fill_q == '0);
   assign wr_elig = bus.wr_req && !full;
   assign rd_elig = bus.rd_req && !empty;
   assign contend = wr_elig && rd_elig;

   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (state_q == StIdle && !bus.fifo_busy) begin
         if (contend) begin
            grant_wr = (last_grant_q == GrantRd);
            grant_rd = (last_grant_q == GrantWr);
         end else begin
            grant_wr = wr_elig;
            grant_rd = rd_elig;
         end
      end
   end

   assign timer_clear = (state_q == StWrIssue) || (state_q == StRdIssue);
   assign timer_en    = (state_q == StWrWait) || (state_q == StRdWait);

   arb_op_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (timer_clear),
      .enable (timer_en),
      .expired(expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         last_grant_q  <= GrantRd;
         fill_q        <= '0;
         rd_data_q     <= '0;
         fifo_din_q    <= '0;
         wr_ack_q      <= 1'b0;
         rd_valid_q    <= 1'b0;
         fifo_we_q     <= 1'b0;
         fifo_re_q     <= 1'b0;
         err_timeout_q <= 1'b0;
         err_ovf_q     <= 1'b0;
         guard_q       <= 1'b0;
      end else begin
         wr_ack_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         fifo_we_q  <= 1'b0;
         fifo_re_q  <= 1'b0;
         if (bus.fifo_ovf) err_ovf_q <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (grant_wr) begin
                  fifo_din_q <= bus.wr_data;
                  fifo_we_q  <= 1'b1;
                  state_q    <= StWrIssue;
                  if (contend) last_grant_q <= GrantWr;
               end else if (grant_rd) begin
                  fifo_re_q <= 1'b1;
                  state_q   <= StRdIssue;
                  if (contend) last_grant_q <= GrantRd;
               end
            end
            StWrIssue: begin
               guard_q <= 1'b1;
               state_q <= StWrWait;
            end
            // fifo_SRAM raises busy a cycle after the strobe, so the first wait cycle is blind.
            StWrWait: begin
               guard_q <= 1'b0;
               if (!guard_q && !bus.fifo_busy) begin
                  wr_ack_q <= 1'b1;
                  fill_q   <= fill_q + 1'b1;
                  state_q  <= StIdle;
               end else if (expired) begin
                  err_timeout_q <= 1'b1;
                  state_q       <= StIdle;
               end
            end
            StRdIssue: begin
               state_q <= StRdWait;
            end
            StRdWait: begin
               if (bus.fifo_rdy) begin
                  rd_data_q  <= bus.fifo_dout;
                  rd_valid_q <= 1'b1;
                  fill_q     <= fill_q - 1'b1;
                  state_q    <= StIdle;
               end else if (expired) begin
                  err_timeout_q <= 1'b1;
                  state_q       <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.wr_ack      = wr_ack_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.fifo_din    = fifo_din_q;
   assign bus.fifo_we     = fifo_we_q;
   assign bus.fifo_re     = fifo_re_q;
   assign bus.fill_count  = fill_q;
   assign bus.full        = full;
   assign bus.empty       = empty;
   assign bus.err_timeout = err_timeout_q;
   assign bus.err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_fifo_sram_arbiter.sv
// Bench for fifo_sram_arbiter with a behavioural fifo_SRAM (busy 3 cycles per op, rdy 4 after re).
module tb_fifo_sram_arbiter;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 64;
   localparam int unsigned DW      = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo_sram_arbiter_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

   fifo_sram_arbiter #(
      .DEPTH  (DEPTH),
      .TIMEOUT(TIMEOUT),
      .DW     (DW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [DW-1:0] sb[$];

   // fifo_SRAM model
   logic [DW-1:0] mem[$];
   int  busy_cnt = 0;
   int  rdy_cnt  = 0;
   bit  rdy_en   = 1'b1;

   always @(posedge clk) begin
      if (rst) begin
         mem.delete();
         busy_cnt      <= 0;
         rdy_cnt       <= 0;
         bus.fifo_busy <= 1'b0;
         bus.fifo_rdy  <= 1'b0;
         bus.fifo_dout <= '0;
      end else begin
         if (bus.fifo_we) mem.push_back(bus.fifo_din);
         if (bus.fifo_we || bus.fifo_re) busy_cnt <= 3;
         else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
         bus.fifo_busy <= bus.fifo_we || bus.fifo_re || (busy_cnt > 1);
         if (bus.fifo_re) rdy_cnt <= 4;
         else if (rdy_cnt > 0) rdy_cnt <= rdy_cnt - 1;
         if (rdy_cnt == 2 && rdy_en && mem.size() != 0) begin
            bus.fifo_rdy  <= 1'b1;
            bus.fifo_dout <= mem.pop_front();
         end else begin
            bus.fifo_rdy <= 1'b0;
         end
      end
   end

   // Event counters, sampled 2 ns after each rising edge
   int  we_cnt = 0, re_cnt = 0, ack_cnt = 0, val_cnt = 0, viol_cnt = 0;
   bit  ack_prev = 1'b0, val_prev = 1'b0;
   always @(posedge clk) begin
      #2;
      if (bus.fifo_we) we_cnt++;
      if (bus.fifo_re) re_cnt++;
      if (bus.wr_ack) ack_cnt++;
      if (bus.rd_valid) val_cnt++;
      if ((bus.wr_ack && bus.rd_valid) || (bus.wr_ack && ack_prev) || (bus.rd_valid && val_prev))
         viol_cnt++;
      ack_prev = bus.wr_ack;
      val_prev = bus.rd_valid;
   end

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      bus.fifo_ovf = 1'b0;
      rdy_en = 1'b1;
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_ack(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.wr_ack) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.rd_valid) begin ok = 1'b1; break; end
      end
   endtask

   task automatic do_write(input logic [DW-1:0] d, output bit ok);
      sb.push_back(d);
      bus.wr_data = d;
      bus.wr_req  = 1'b1;
      wait_ack(ok);
      bus.wr_req = 1'b0;
   endtask

   task automatic do_read(output bit ok, output logic [DW-1:0] d, output logic [DW-1:0] exp);
      bus.rd_req = 1'b1;
      wait_valid(ok);
      d = bus.rd_data;
      bus.rd_req = 1'b0;
      exp = (sb.size() != 0) ? sb.pop_front() : 'x;
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if (bus.fill_count !== 0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_count: fill=%0d empty=%b full=%b, required 0/1/0",
                  bus.fill_count, bus.empty, bus.full);
      end
      n_cmp++;
      if ({bus.fifo_we, bus.fifo_re, bus.wr_ack, bus.rd_valid, bus.err_timeout, bus.err_ovf}
          !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_flags: we/re/ack/valid/errt/erro=%b%b%b%b%b%b, required 000000",
                  bus.fifo_we, bus.fifo_re, bus.wr_ack, bus.rd_valid, bus.err_timeout, bus.err_ovf);
      end
      n_cmp++;
      if (bus.rd_data !== '0 || bus.fifo_din !== '0) begin
         n_bad++;
         $display("FAIL reset_data: rd_data=%h fifo_din=%h, required 0", bus.rd_data, bus.fifo_din);
      end
   endtask

   task automatic test_single_rw();
      bit ok;
      int we0, re0;
      logic [DW-1:0] d, exp;
      apply_reset();
      we0 = we_cnt;
      do_write(32'h5, ok);
      n_cmp++;
      if (!ok || we_cnt - we0 != 1 || bus.fill_count !== 1) begin
         n_bad++;
         $display("FAIL single_write: ack=%b we_pulses=%0d fill=%0d, required 1/1/1",
                  ok, we_cnt - we0, bus.fill_count);
      end
      re0 = re_cnt;
      do_read(ok, d, exp);
      n_cmp++;
      if (!ok || d !== exp || d !== 32'h5) begin
         n_bad++;
         $display("FAIL single_read: valid=%b rd_data=%h, required 1/%h", ok, d, exp);
      end
      n_cmp++;
      if (re_cnt - re0 != 1 || bus.fill_count !== 0 || bus.empty !== 1'b1) begin
         n_bad++;
         $display("FAIL single_read_count: re_pulses=%0d fill=%0d, required 1/0",
                  re_cnt - re0, bus.fill_count);
      end
   endtask

   task automatic test_contention();
      bit ok, exp_rd, done;
      int acks, vals;
      logic [DW-1:0] next_w, exp;
      apply_reset();
      do_write(32'h10, ok);
      do_write(32'h11, ok);
      n_cmp++;
      if (bus.fill_count !== 2) begin
         n_bad++;
         $display("FAIL contend_prefill: fill=%0d, required 2", bus.fill_count);
      end
      exp_rd = 1'b0;
      done = 1'b0;
      acks = 0;
      vals = 0;
      next_w = 32'h20;
      bus.wr_data = next_w;
      bus.wr_req = 1'b1;
      bus.rd_req = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (bus.fifo_we || bus.fifo_re) begin
            n_cmp++;
            if (bus.fifo_re !== exp_rd || bus.fifo_we !== !exp_rd) begin
               n_bad++;
               $display("FAIL contend_order: op %0d we=%b re=%b, required re=%b",
                        acks + vals, bus.fifo_we, bus.fifo_re, exp_rd);
            end
            exp_rd = !exp_rd;
         end
         if (bus.wr_ack) begin
            acks++;
            sb.push_back(next_w);
            next_w = next_w + 1;
            bus.wr_data = next_w;
         end
         if (bus.rd_valid) begin
            vals++;
            exp = (sb.size() != 0) ? sb.pop_front() : 'x;
            n_cmp++;
            if (bus.rd_data !== exp) begin
               n_bad++;
               $display("FAIL contend_data: rd_data=%h, required %h", bus.rd_data, exp);
            end
         end
         if (acks + vals == 8) begin
            bus.wr_req = 1'b0;
            bus.rd_req = 1'b0;
            done = 1'b1;
            break;
         end
      end
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      n_cmp++;
      if (!done || acks != 4 || vals != 4 || bus.fill_count !== 2) begin
         n_bad++;
         $display("FAIL contend_totals: done=%b acks=%0d valids=%0d fill=%0d, required 1/4/4/2",
                  done, acks, vals, bus.fill_count);
      end
   endtask

   task automatic test_full();
      bit ok, seen_ack;
      int we0;
      logic [DW-1:0] d, exp;
      apply_reset();
      for (int i = 0; i < 4; i++) do_write(DW'(6 + i), ok);
      n_cmp++;
      if (bus.full !== 1'b1 || bus.fill_count !== 4) begin
         n_bad++;
         $display("FAIL full_flag: full=%b fill=%0d, required 1/4", bus.full, bus.fill_count);
      end
      we0 = we_cnt;
      seen_ack = 1'b0;
      bus.wr_data = 32'hA;
      bus.wr_req = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (bus.wr_ack) seen_ack = 1'b1;
      end
      n_cmp++;
      if (we_cnt != we0 || seen_ack || bus.fill_count !== 4) begin
         n_bad++;
         $display("FAIL full_block: we_pulses=%0d ack=%b fill=%0d, required 0/0/4",
                  we_cnt - we0, seen_ack, bus.fill_count);
      end
      do_read(ok, d, exp);
      n_cmp++;
      if (!ok || d !== exp || d !== 32'h6) begin
         n_bad++;
         $display("FAIL full_read: valid=%b rd_data=%h, required 1/%h", ok, d, exp);
      end
      sb.push_back(32'hA);
      wait_ack(ok);
      bus.wr_req = 1'b0;
      n_cmp++;
      if (!ok || bus.fill_count !== 4) begin
         n_bad++;
         $display("FAIL full_retry: ack=%b fill=%0d, required 1/4", ok, bus.fill_count);
      end
   endtask

   task automatic test_empty_read();
      bit ok;
      int re0, we0;
      logic [DW-1:0] exp;
      apply_reset();
      re0 = re_cnt;
      bus.rd_req = 1'b1;
      repeat (20) @(negedge clk);
      n_cmp++;
      if (re_cnt != re0 || bus.empty !== 1'b1 || bus.rd_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL empty_block: re_pulses=%0d empty=%b, required 0/1", re_cnt - re0, bus.empty);
      end
      do_write(32'h7, ok);
      re0 = re_cnt;
      we0 = we_cnt;
      wait_valid(ok);
      bus.rd_req = 1'b0;
      exp = (sb.size() != 0) ? sb.pop_front() : 'x;
      n_cmp++;
      if (!ok || bus.rd_data !== exp || bus.rd_data !== 32'h7) begin
         n_bad++;
         $display("FAIL empty_then_read: valid=%b rd_data=%h, required 1/%h", ok, bus.rd_data, exp);
      end
      n_cmp++;
      if (re_cnt - re0 != 1 || we_cnt != we0 || bus.fill_count !== 0) begin
         n_bad++;
         $display("FAIL empty_then_read_ops: re=%0d we=%0d fill=%0d, required 1/0/0",
                  re_cnt - re0, we_cnt - we0, bus.fill_count);
      end
   endtask

   task automatic test_timeout();
      bit ok, seen_re, seen_err;
      int val0, cycles;
      logic [DW-1:0] d, exp;
      apply_reset();
      do_write(32'h3, ok);
      rdy_en = 1'b0;
      val0 = val_cnt;
      seen_re = 1'b0;
      seen_err = 1'b0;
      cycles = 0;
      bus.rd_req = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (seen_re) cycles++;
         if (bus.fifo_re && !seen_re) seen_re = 1'b1;
         if (bus.err_timeout) begin seen_err = 1'b1; break; end
      end
      bus.rd_req = 1'b0;
      n_cmp++;
      if (!seen_err || cycles < TIMEOUT || cycles > TIMEOUT + 4) begin
         n_bad++;
         $display("FAIL timeout_flag: err=%b cycles=%0d, required 1/%0d..%0d",
                  seen_err, cycles, TIMEOUT, TIMEOUT + 4);
      end
      n_cmp++;
      if (val_cnt != val0 || bus.fill_count !== 1) begin
         n_bad++;
         $display("FAIL timeout_state: valids=%0d fill=%0d, required 0/1",
                  val_cnt - val0, bus.fill_count);
      end
      rdy_en = 1'b1;
      repeat (5) @(negedge clk);
      do_read(ok, d, exp);
      n_cmp++;
      if (!ok || d !== exp || d !== 32'h3 || bus.err_timeout !== 1'b1) begin
         n_bad++;
         $display("FAIL timeout_recover: valid=%b rd_data=%h err=%b, required 1/%h/1",
                  ok, d, bus.err_timeout, exp);
      end
   endtask

   task automatic test_reset_mid_op();
      bit seen_we;
      int ack0;
      apply_reset();
      seen_we = 1'b0;
      bus.wr_data = 32'h1;
      bus.wr_req = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.fifo_we) begin seen_we = 1'b1; break; end
      end
      @(negedge clk);
      rst = 1'b1;
      bus.wr_req = 1'b0;
      ack0 = ack_cnt;
      @(negedge clk);
      n_cmp++;
      if (!seen_we || bus.fifo_we !== 1'b0 || bus.fifo_re !== 1'b0 || bus.wr_ack !== 1'b0 ||
          bus.fill_count !== 0) begin
         n_bad++;
         $display("FAIL midop_reset: seen_we=%b we=%b re=%b ack=%b fill=%0d, required 1/0/0/0/0",
                  seen_we, bus.fifo_we, bus.fifo_re, bus.wr_ack, bus.fill_count);
      end
      rst = 1'b0;
      repeat (10) @(negedge clk);
      n_cmp++;
      if (ack_cnt != ack0 || bus.fill_count !== 0 || bus.err_ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL midop_after: acks=%0d fill=%0d err_ovf=%b, required 0/0/0",
                  ack_cnt - ack0, bus.fill_count, bus.err_ovf);
      end
      bus.fifo_ovf = 1'b1;
      @(negedge clk);
      bus.fifo_ovf = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (bus.err_ovf !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_sticky: err_ovf=%b, required 1", bus.err_ovf);
      end
   endtask

   task automatic test_invariants();
      n_cmp++;
      if (viol_cnt != 0) begin
         n_bad++;
         $display("FAIL pulse_rules: violations=%0d, required 0", viol_cnt);
      end
   endtask

   initial begin
      bus.wr_req   = 1'b0;
      bus.wr_data  = '0;
      bus.rd_req   = 1'b0;
      bus.fifo_ovf = 1'b0;
      test_reset();
      test_single_rw();
      test_contention();
      test_full();
      test_empty_read();
      test_timeout();
      test_reset_mid_op();
      test_invariants();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
